// File: rtl/kmap_pkg.sv
// ============================================================================
// kmap_pkg
// Shared types and constants for the K-map evaluator sweep controller.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package kmap_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam int CNT_W   = 5;

  // Golden truth tables; bit i is the function value at input index i.
  localparam logic [NUM_VEC-1:0] F1_MASK_DEFAULT = 16'h35A5;
  localparam logic [NUM_VEC-1:0] F2_MASK_DEFAULT = 16'hEEE2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } kmap_state_e;

endpackage

`default_nettype wire

// File: rtl/kmap_golden_lut.sv
// ============================================================================
// kmap_golden_lut
// Combinational lookup of the expected f1/f2 values at the current vector.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module kmap_golden_lut
  import kmap_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] F1_MINTERMS = F1_MASK_DEFAULT,
  parameter logic [NUM_VEC-1:0] F2_MINTERMS = F2_MASK_DEFAULT
) (
  input  logic [VEC_W-1:0] vec_i,
  output logic             exp_f1_o,
  output logic             exp_f2_o
);

  assign exp_f1_o = F1_MINTERMS[vec_i];
  assign exp_f2_o = F2_MINTERMS[vec_i];

endmodule

`default_nettype wire

// File: rtl/kmap_sweep_ctrl.sv
// ============================================================================
// kmap_sweep_ctrl
// Built-in self-test sequencer: walks all 16 input vectors through the SOP
// evaluator, counts f1/f2 mismatches and records the first failing vector.
// Optional build macro: KMAP_STOP_ON_FAIL_EN (end sweep at first mismatch).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module kmap_sweep_ctrl
  import kmap_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] F1_MINTERMS = F1_MASK_DEFAULT,
  parameter logic [NUM_VEC-1:0] F2_MINTERMS = F2_MASK_DEFAULT,
  parameter int                 DUT_LAT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] vec_out,
  input  logic             f1_in,
  input  logic             f2_in,
  output logic [CNT_W-1:0] f1_err_cnt,
  output logic [CNT_W-1:0] f2_err_cnt,
  output logic             fail_seen,
  output logic [VEC_W-1:0] first_fail_idx,
  output logic             pass
);

  kmap_state_e      state_q, state_d;
  logic [2:0]       wait_q, wait_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] c1_q, c1_d;
  logic [CNT_W-1:0] c2_q, c2_d;
  logic             fs_q, fs_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic             pass_q, pass_d;

  logic             exp_f1, exp_f2;
  logic             mis_f1, mis_f2;
  logic             last_vec;

  // With zero evaluator latency every vector is sampled immediately.
  localparam kmap_state_e VEC_ENTRY_ST = (DUT_LAT == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [2:0]  WAIT_INIT    = 3'(DUT_LAT - 1);

  kmap_golden_lut #(
    .F1_MINTERMS (F1_MINTERMS),
    .F2_MINTERMS (F2_MINTERMS)
  ) u_lut (
    .vec_i    (vec_q),
    .exp_f1_o (exp_f1),
    .exp_f2_o (exp_f2)
  );

  assign mis_f1 = f1_in ^ exp_f1;
  assign mis_f2 = f2_in ^ exp_f2;

`ifdef KMAP_STOP_ON_FAIL_EN
  assign last_vec = mis_f1 | mis_f2 | (vec_q == VEC_W'(NUM_VEC - 1));
`else
  assign last_vec = (vec_q == VEC_W'(NUM_VEC - 1));
`endif

  // Next-state and datapath update for the sweep sequencer.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    vec_d   = vec_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    fs_d    = fs_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          c1_d    = '0;
          c2_d    = '0;
          fs_d    = 1'b0;
          idx_d   = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          wait_d  = WAIT_INIT;
          state_d = VEC_ENTRY_ST;
        end
      end
      ST_SETTLE: begin
        if (wait_q == 3'd0) state_d = ST_SAMPLE;
        else                wait_d  = wait_q - 3'd1;
      end
      ST_SAMPLE: begin
        if (mis_f1) c1_d = c1_q + CNT_W'(1);
        if (mis_f2) c2_d = c2_q + CNT_W'(1);
        if ((mis_f1 | mis_f2) && !fs_q) begin
          fs_d  = 1'b1;
          idx_d = vec_q;
        end
        if (last_vec) begin
          pass_d  = ~(fs_q | mis_f1 | mis_f2);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          wait_d  = WAIT_INIT;
          state_d = VEC_ENTRY_ST;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any sweep in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= 3'd0;
      vec_q   <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      fs_q    <= 1'b0;
      idx_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      vec_q   <= vec_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      fs_q    <= fs_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
    end
  end

  assign busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done           = (state_q == ST_DONE);
  assign vec_out        = vec_q;
  assign f1_err_cnt     = c1_q;
  assign f2_err_cnt     = c2_q;
  assign fail_seen      = fs_q;
  assign first_fail_idx = idx_q;
  assign pass           = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_kmap_sweep_ctrl.sv
// ============================================================================
// tb_kmap_sweep_ctrl
// Self-checking bench: two controllers (evaluator latency 0 and 2) driven by
// behavioural evaluators; expected sweep results are queued at start and
// compared when done is seen.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kmap_sweep_ctrl;

  localparam logic [15:0] GOLD_F1 = 16'h35A5;
  localparam logic [15:0] GOLD_F2 = 16'hEEE2;

  typedef struct {
    logic [4:0] c1;
    logic [4:0] c2;
    logic       fs;
    logic [3:0] idx;
    logic       pass;
    logic [3:0] vlast;
    int         lat;
    bit         exact;
  } exp_t;

  typedef struct {
    logic       busy;
    logic       done;
    logic [3:0] vec;
    logic [4:0] c1;
    logic [4:0] c2;
    logic       fs;
    logic [3:0] idx;
    logic       pass;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start2;
  logic       busy0, done0, fs0, pass0, busy2, done2, fs2, pass2;
  logic [3:0] vec0, idx0, vec2, idx2;
  logic [4:0] c1_0, c2_0, c1_2, c2_2;
  logic [1:0] comb0, p0a, p0b, p2a, p2b;
  logic       f1_0, f2_0;
  int         mode0;
  int         cyc;
  int         n_err, n_chk;
  exp_t       sb_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Evaluator models; mode 5 is the correct evaluator behind 2 pipeline regs.
  function automatic logic [1:0] eval_fn(input int mode, input logic [3:0] v);
    logic a, b, c, d, f1c, f2c, f2n;
    {a, b, c, d} = v;
    f1c = (~b & ~d) | (~a & b & d) | (a & b & ~c);
    f2c = (~c & d) | (a & c) | (b & c);
    f2n = (~c & d) | (a & c);
    case (mode)
      1:       return {1'b0, f2c};
      2:       return {f1c, f2n};
      3:       return {1'b1, f2c};
      4:       return {~f1c, ~f2c};
      default: return {f1c, f2c};
    endcase
  endfunction

  assign comb0 = eval_fn(mode0, vec0);
  assign f1_0  = (mode0 == 5) ? p0b[1] : comb0[1];
  assign f2_0  = (mode0 == 5) ? p0b[0] : comb0[0];

  always @(posedge clk) begin
    p0a <= eval_fn(0, vec0);
    p0b <= p0a;
    p2a <= eval_fn(0, vec2);
    p2b <= p2a;
  end

  kmap_sweep_ctrl #(.DUT_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .vec_out(vec0), .f1_in(f1_0), .f2_in(f2_0), .f1_err_cnt(c1_0),
    .f2_err_cnt(c2_0), .fail_seen(fs0), .first_fail_idx(idx0), .pass(pass0)
  );

  kmap_sweep_ctrl #(.DUT_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .vec_out(vec2), .f1_in(p2b[1]), .f2_in(p2b[0]), .f1_err_cnt(c1_2),
    .f2_err_cnt(c2_2), .fail_seen(fs2), .first_fail_idx(idx2), .pass(pass2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t snap(input bit use2);
    obs_t o;
    o.busy = use2 ? busy2 : busy0;
    o.done = use2 ? done2 : done0;
    o.vec  = use2 ? vec2  : vec0;
    o.c1   = use2 ? c1_2  : c1_0;
    o.c2   = use2 ? c2_2  : c2_0;
    o.fs   = use2 ? fs2   : fs0;
    o.idx  = use2 ? idx2  : idx0;
    o.pass = use2 ? pass2 : pass0;
    return o;
  endfunction

  // Reference result of a sweep computed from the golden masks.
  function automatic exp_t model(input int mode, input int lat);
    exp_t       e;
    logic [1:0] f;
    logic       m1, m2;
    int         last;
    e.c1 = '0; e.c2 = '0; e.fs = 1'b0; e.idx = '0;
    e.exact = (mode != 5);
    last = 15;
    for (int i = 0; i < 16; i++) begin
      f  = eval_fn(mode, 4'(i));
      m1 = (f[1] != GOLD_F1[i]);
      m2 = (f[0] != GOLD_F2[i]);
      if (m1) e.c1 = e.c1 + 5'd1;
      if (m2) e.c2 = e.c2 + 5'd1;
      if ((m1 || m2) && !e.fs) begin
        e.fs  = 1'b1;
        e.idx = 4'(i);
      end
`ifdef KMAP_STOP_ON_FAIL_EN
      if (m1 || m2) begin
        last = i;
        break;
      end
`endif
    end
    e.vlast = 4'(last);
    e.pass  = (mode == 5) ? 1'b0 : !e.fs;
    e.lat   = (last + 1) * (lat + 1) + 1;
    return e;
  endfunction

  task automatic check_reset(input bit use2, input string tag);
    obs_t o;
    o = snap(use2);
    check({tag, "_busy"}, 32'(o.busy), 0);
    check({tag, "_done"}, 32'(o.done), 0);
    check({tag, "_vec"},  32'(o.vec),  0);
    check({tag, "_cnt1"}, 32'(o.c1),   0);
    check({tag, "_cnt2"}, 32'(o.c2),   0);
    check({tag, "_fail"}, 32'(o.fs),   0);
    check({tag, "_idx"},  32'(o.idx),  0);
    check({tag, "_pass"}, 32'(o.pass), 0);
  endtask

  task automatic run_sweep(input bit use2, input int mode, input string tag);
    exp_t e;
    obs_t o;
    int   t0;
    bit   seen;
    if (!use2) mode0 = mode;
    sb_q.push_back(model(mode, use2 ? 2 : 0));
    @(negedge clk);
    if (use2) start2 = 1'b1; else start0 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start0 = 1'b0;
    start2 = 1'b0;
    o = snap(use2);
    check({tag, "_busy"}, 32'(o.busy), 1);
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (snap(use2).done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    e = sb_q.pop_front();
    if (!seen) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      o = snap(use2);
      check({tag, "_pass"}, 32'(o.pass), 32'(e.pass));
      if (e.exact) begin
        check({tag, "_lat"},  32'(cyc - t0), 32'(e.lat));
        check({tag, "_cnt1"}, 32'(o.c1),     32'(e.c1));
        check({tag, "_cnt2"}, 32'(o.c2),     32'(e.c2));
        check({tag, "_fail"}, 32'(o.fs),     32'(e.fs));
        check({tag, "_idx"},  32'(o.idx),    32'(e.idx));
        check({tag, "_vec"},  32'(o.vec),    32'(e.vlast));
      end else begin
        check({tag, "_mis_nonzero"}, 32'((o.c1 + o.c2) != 0), 1);
      end
      @(negedge clk);
      o = snap(use2);
      check({tag, "_done_pulse"}, 32'(o.done), 0);
      check({tag, "_pass_hold"},  32'(o.pass), 32'(e.pass));
    end
  endtask

  task automatic abort_test();
    int t0;
    int pulses;
    mode0 = 0;
    @(negedge clk);
    start0 = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    check("abort_vec_cont", 32'(vec0), 9);
    check("abort_busy", 32'(busy0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset(1'b0, "abort_rst");
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      if (done0) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(pulses), 0);
  endtask

  initial begin
    n_err  = 0;
    n_chk  = 0;
    cyc    = 0;
    mode0  = 0;
    rst    = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset(1'b0, "rst0");
    check_reset(1'b1, "rst2");

    run_sweep(1'b0, 0, "good_l0");
    run_sweep(1'b0, 1, "f1_stuck0");
    run_sweep(1'b0, 2, "f2_no_xy");
    run_sweep(1'b0, 4, "both_inv");
    run_sweep(1'b0, 3, "f1_stuck1");
    run_sweep(1'b1, 0, "good_l2");
    run_sweep(1'b0, 5, "pipe_vs_l0");
    abort_test();
    run_sweep(1'b0, 0, "after_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
